// File: rtl/oam_write_arbiter.sv
// oam_write_arbiter: shares single-port sprite OAM between PPU reads and buffered CPU writes
module oam_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_oam_we,
  input  logic [ADDR_W-1:0] cpu_oam_addr,
  input  logic [DATA_W-1:0] cpu_oam_data,
  output logic              cpu_stall,
  input  logic              ppu_rd_req,
  input  logic [ADDR_W-1:0] ppu_rd_addr,
  output logic [DATA_W-1:0] ppu_rd_data,
  output logic              ppu_rd_valid,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [ADDR_W-1:0] oam_addr,
  output logic [DATA_W-1:0] oam_wdata,
  output logic              oam_we,
  input  logic [DATA_W-1:0] oam_rdata
);
  localparam int ptr_w = $clog2(DEPTH);
  localparam logic [ptr_w:0] full_cnt = (ptr_w+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ptr_w-1:0] rd_ptr, wr_ptr;
  logic [ptr_w:0] count, count_nxt;
  logic accept, direct, enq, deq;
  logic [ADDR_W-1:0] last_addr;
  logic fwd_hit, hit_q;
  logic [DATA_W-1:0] fwd_data, fwd_q;
  // Outputs are gated by rst_n so they drop to zero the moment reset asserts
  assign cpu_stall = rst_n && cpu_oam_we && (count == full_cnt || state == DRAIN);
  assign accept = rst_n && cpu_oam_we && !cpu_stall;
  assign direct = accept && !ppu_rd_req && count == '0;
  assign enq = accept && !direct;
  assign deq = rst_n && !ppu_rd_req && count != '0;
  assign count_nxt = count + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
  assign oam_we = deq || direct;
  assign oam_addr = !rst_n ? '0 : ppu_rd_req ? ppu_rd_addr : deq ? buf_addr[rd_ptr] :
                    direct ? cpu_oam_addr : last_addr;
  assign oam_wdata = deq ? buf_data[rd_ptr] : direct ? cpu_oam_data : '0;
  assign ppu_rd_data = !ppu_rd_valid ? '0 : hit_q ? fwd_q : oam_rdata;
  // Scan oldest to newest so the latest matching entry wins; a same-cycle write is newest of all
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ptr_w+1)'(i) < count && buf_addr[rd_ptr + ptr_w'(i)] == ppu_rd_addr) begin
        fwd_hit = 1'b1;
        fwd_data = buf_data[rd_ptr + ptr_w'(i)];
      end
    end
    if (enq && cpu_oam_addr == ppu_rd_addr) begin
      fwd_hit = 1'b1;
      fwd_data = cpu_oam_data;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr[wr_ptr] <= cpu_oam_addr;
      buf_data[wr_ptr] <= cpu_oam_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ppu_rd_valid <= 1'b0;
      hit_q <= 1'b0;
      fwd_q <= '0;
      last_addr <= '0;
      drain_done <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + ptr_w'(deq);
      wr_ptr <= wr_ptr + ptr_w'(enq);
      count <= count_nxt;
      ppu_rd_valid <= ppu_rd_req;
      hit_q <= ppu_rd_req && fwd_hit;
      fwd_q <= fwd_data;
      if (ppu_rd_req || oam_we) last_addr <= oam_addr;
      drain_done <= 1'b0;
      if (state == DRAIN) begin
        if (count_nxt == '0) begin
          state <= IDLE;
          drain_done <= 1'b1;
        end
      end else if (drain_req && count_nxt != '0) begin
        state <= DRAIN;
      end else begin
        state <= count_nxt != '0 ? BUSY : IDLE;
        drain_done <= drain_req;
      end
    end
  end
endmodule

// File: tb/tb_oam_write_arbiter.sv
// tb_oam_write_arbiter: scoreboard bench with an OAM RAM model and a shadow of CPU-visible OAM contents
module tb_oam_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_oam_we = 1'b0;
  logic [5:0] cpu_oam_addr = '0;
  logic [31:0] cpu_oam_data = '0;
  logic cpu_stall;
  logic ppu_rd_req = 1'b0;
  logic [5:0] ppu_rd_addr = '0;
  logic [31:0] ppu_rd_data;
  logic ppu_rd_valid;
  logic drain_req = 1'b0;
  logic drain_done;
  logic [5:0] oam_addr;
  logic [31:0] oam_wdata;
  logic oam_we;
  logic [31:0] oam_rdata;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  logic [31:0] saved [64];
  logic [37:0] wr_q [$];
  logic [31:0] rd_q [$];
  logic s_we, s_done;
  logic [5:0] s_addr;

  always #5 clk = ~clk;

  oam_write_arbiter #(.ADDR_W(6), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_oam_we(cpu_oam_we), .cpu_oam_addr(cpu_oam_addr),
    .cpu_oam_data(cpu_oam_data), .cpu_stall(cpu_stall), .ppu_rd_req(ppu_rd_req),
    .ppu_rd_addr(ppu_rd_addr), .ppu_rd_data(ppu_rd_data), .ppu_rd_valid(ppu_rd_valid),
    .drain_req(drain_req), .drain_done(drain_done), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;

  always @(posedge clk) begin
    if (oam_we) mem[oam_addr] <= oam_wdata;
    oam_rdata <= mem[oam_addr];
  end

  // Scoreboard: OAM writes must appear in CPU acceptance order, reads must see the newest accepted data
  always @(negedge clk) begin
    if (rst_n) begin
      if (oam_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL oam_write unexpected: addr=%0d data=%h, none required", oam_addr, oam_wdata);
        end else begin
          logic [37:0] e;
          e = wr_q.pop_front();
          if ({oam_addr, oam_wdata} !== e) begin
            errors++;
            $display("FAIL oam_write order: got addr=%0d data=%h, required addr=%0d data=%h",
                     oam_addr, oam_wdata, e[37:32], e[31:0]);
          end
        end
      end
      if (ppu_rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL ppu_read unexpected valid: data=%h", ppu_rd_data);
        end else begin
          logic [31:0] r;
          r = rd_q.pop_front();
          if (ppu_rd_data !== r) begin
            errors++;
            $display("FAIL ppu_read data: got %h, required %h", ppu_rd_data, r);
          end
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [5:0] a, input logic [31:0] d,
                       input logic rd, input logic [5:0] ra, input logic dr, input logic exp_stall);
    cpu_oam_we = we;
    cpu_oam_addr = a;
    cpu_oam_data = d;
    ppu_rd_req = rd;
    ppu_rd_addr = ra;
    drain_req = dr;
    if (we && !exp_stall) begin
      wr_q.push_back({a, d});
      shadow[a] = d;
    end
    if (rd) rd_q.push_back(shadow[ra]);
    @(negedge clk);
    s_we = oam_we;
    s_done = drain_done;
    s_addr = oam_addr;
    checks++;
    if (cpu_stall !== exp_stall) begin
      errors++;
      $display("FAIL cpu_stall: got %b, required %b (we=%b addr=%0d)", cpu_stall, exp_stall, we, a);
    end
    @(posedge clk);
    #1;
    cpu_oam_we = 1'b0;
    ppu_rd_req = 1'b0;
    drain_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 50 && wr_q.size() != 0; i++) idle(1);
    idle(2);
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d writes %0d reads outstanding, required 0", wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 7;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset cpu_stall: got %b, required 0", cpu_stall); end
    if (ppu_rd_valid !== 1'b0) begin errors++; $display("FAIL reset ppu_rd_valid: got %b, required 0", ppu_rd_valid); end
    if (drain_done !== 1'b0) begin errors++; $display("FAIL reset drain_done: got %b, required 0", drain_done); end
    if (oam_we !== 1'b0) begin errors++; $display("FAIL reset oam_we: got %b, required 0", oam_we); end
    if (oam_addr !== 6'd0) begin errors++; $display("FAIL reset oam_addr: got %0d, required 0", oam_addr); end
    if (oam_wdata !== 32'd0) begin errors++; $display("FAIL reset oam_wdata: got %h, required 0", oam_wdata); end
    if (ppu_rd_data !== 32'd0) begin errors++; $display("FAIL reset ppu_rd_data: got %h, required 0", ppu_rd_data); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_direct();
    drive(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (s_we !== 1'b1 || s_addr !== 6'd5) begin
      errors++;
      $display("FAIL direct_write: got we=%b addr=%0d, required we=1 addr=5", s_we, s_addr);
    end
    idle(1);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 1'b0, 1'b0);
    wait_drained();
  endtask

  task automatic test_collision();
    drive(1'b1, 6'd3, 32'h11, 1'b1, 6'd10, 1'b0, 1'b0);
    checks++;
    if (s_we !== 1'b0) begin errors++; $display("FAIL collision_we first: got %b, required 0", s_we); end
    drive(1'b1, 6'd3, 32'h22, 1'b1, 6'd3, 1'b0, 1'b0);
    checks++;
    if (s_we !== 1'b0) begin errors++; $display("FAIL collision_we second: got %b, required 0", s_we); end
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b0, 1'b0);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 1'b0, 1'b0);
    wait_drained();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b0, 1'b0);
    wait_drained();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 6'(20 + i), 32'h100 + i, 1'b1, 6'(20 + i), 1'b0, 1'b0);
    drive(1'b1, 6'd24, 32'h104, 1'b1, 6'd22, 1'b0, 1'b1);
    drive(1'b1, 6'd24, 32'h104, 1'b0, 6'd0, 1'b0, 1'b1);
    checks++;
    if (s_we !== 1'b1 || s_addr !== 6'd20) begin
      errors++;
      $display("FAIL full_dequeue: got we=%b addr=%0d, required we=1 addr=20", s_we, s_addr);
    end
    drive(1'b1, 6'd24, 32'h104, 1'b0, 6'd0, 1'b0, 1'b0);
    wait_drained();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 6'(30 + i), 32'h300 + i, 1'b1, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd31, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd33, 32'h333, 1'b0, 6'd0, 1'b0, 1'b1);
      checks++;
      if (s_we !== 1'b1 || s_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_step %0d: got we=%b done=%b, required we=1 done=0", i, s_we, s_done);
      end
    end
    drive(1'b1, 6'd33, 32'h333, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (s_done !== 1'b1 || s_we !== 1'b1) begin
      errors++;
      $display("FAIL drain_done pulse: got done=%b we=%b, required done=1 we=1", s_done, s_we);
    end
    idle(1);
    checks++;
    if (s_done !== 1'b0) begin errors++; $display("FAIL drain_done width: got %b, required 0", s_done); end
    wait_drained();
  endtask

  task automatic test_empty_drain();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    checks++;
    if (s_done !== 1'b0) begin errors++; $display("FAIL empty_drain early: got %b, required 0", s_done); end
    drive(1'b1, 6'd34, 32'h3434, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (s_done !== 1'b1) begin errors++; $display("FAIL empty_drain pulse: got %b, required 1", s_done); end
    idle(1);
    checks++;
    if (s_done !== 1'b0) begin errors++; $display("FAIL empty_drain width: got %b, required 0", s_done); end
    wait_drained();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 64; i++) saved[i] = shadow[i];
    drive(1'b1, 6'd40, 32'h4040, 1'b1, 6'd0, 1'b0, 1'b0);
    drive(1'b1, 6'd41, 32'h4141, 1'b1, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 1'b1, 1'b0);
    cpu_oam_we = 1'b1;
    cpu_oam_addr = 6'd42;
    ppu_rd_req = 1'b1;
    ppu_rd_addr = 6'd9;
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL midreset cpu_stall: got %b, required 0", cpu_stall); end
    if (oam_we !== 1'b0) begin errors++; $display("FAIL midreset oam_we: got %b, required 0", oam_we); end
    if (oam_addr !== 6'd0) begin errors++; $display("FAIL midreset oam_addr: got %0d, required 0", oam_addr); end
    if (ppu_rd_valid !== 1'b0) begin errors++; $display("FAIL midreset ppu_rd_valid: got %b, required 0", ppu_rd_valid); end
    if (ppu_rd_data !== 32'd0) begin errors++; $display("FAIL midreset ppu_rd_data: got %h, required 0", ppu_rd_data); end
    cpu_oam_we = 1'b0;
    ppu_rd_req = 1'b0;
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < 64; i++) shadow[i] = saved[i];
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    drive(1'b1, 6'd45, 32'h4545, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (s_we !== 1'b1) begin errors++; $display("FAIL midreset count_cleared: got we=%b, required 1", s_we); end
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd40, 1'b0, 1'b0);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd41, 1'b0, 1'b0);
    wait_drained();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'hA500_0000 | i;
    test_reset();
    test_direct();
    test_collision();
    test_full();
    test_drain();
    test_empty_drain();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_write_arbiter.md
# oam_write_arbiter

Shares the single-port sprite OAM between CPU sprite-store writes (the `OAMWrite` path from the pipeline's memory stage) and the PPU's sprite-evaluation reads. The PPU always has priority. CPU writes that collide with PPU reads are parked in a small ordered write buffer and drained in idle cycles. Pending buffered data is forwarded to PPU reads, and the CPU pipeline is stalled only when the buffer is full or a drain is being forced.

## Interface
Parameters:
- `ADDR_W`, 6, OAM word address width (64 sprite entries)
- `DATA_W`, 32, OAM word width
- `DEPTH`, 4, write-buffer entries; power of two, ≥2

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cpu_oam_we`  in  1  CPU OAM write request (OAMWrite from control, MEM stage)
- `cpu_oam_addr`  in  ADDR_W  CPU write address
- `cpu_oam_data`  in  DATA_W  CPU write data
- `cpu_stall`  out  1  write not accepted this cycle; pipeline holds the instruction
- `ppu_rd_req`  in  1  PPU read request, one word per cycle
- `ppu_rd_addr`  in  ADDR_W  PPU read address
- `ppu_rd_data`  out  DATA_W  read data
- `ppu_rd_valid`  out  1  `ppu_rd_data` valid
- `drain_req`  in  1  single-cycle pulse: empty the buffer (frame start)
- `drain_done`  out  1  single-cycle pulse: forced drain complete
- `oam_addr`  out  ADDR_W  OAM RAM address
- `oam_wdata`  out  DATA_W  OAM RAM write data
- `oam_we`  out  1  OAM RAM write enable
- `oam_rdata`  in  DATA_W  OAM RAM read data (synchronous, 1-cycle latency)

## Operation
- **Buffer.** FIFO of `DEPTH` {addr, data} entries with wrapping read and write pointers and a count of 0..DEPTH.
- **OAM port owner each cycle,** in strict priority:
  1. PPU read when `ppu_rd_req`.
  2. Buffer head write (dequeue) when count>0.
  3. Direct CPU write when `cpu_oam_we` and count==0. This bypasses the buffer.
  4. Otherwise idle: `oam_we`=0, `oam_addr` holds its last value.
- **Enqueue.** An accepted `cpu_oam_we` that does not win the port is enqueued. Accepted means `cpu_oam_we && !cpu_stall`. Ordering is preserved because a direct write is only allowed when the buffer is empty.
- **Stall.** `cpu_stall` = `cpu_oam_we && (count==DEPTH || state==DRAIN)`. The count is sampled before any same-cycle dequeue, so a full buffer stalls even while it drains.
- **Forwarding.** On `ppu_rd_req`, the newest buffer entry whose addr equals `ppu_rd_addr` is captured. A same-cycle accepted CPU write to the same address is newer and takes precedence over buffer entries. If there is no hit, the OAM array data is returned.
- **FSM states:**
  - IDLE: count==0.
  - BUSY: count>0.
  - DRAIN: forced drain.
- **FSM transitions:**
  - IDLE→BUSY on enqueue.
  - BUSY→IDLE when count reaches 0.
  - IDLE/BUSY→DRAIN on `drain_req` with post-update count>0.
  - DRAIN→IDLE when count reaches 0; `drain_done` pulses in that cycle.
  - `drain_req` with post-update count==0 pulses `drain_done` on the next cycle and stays in IDLE.
  - `drain_req` while already in DRAIN is ignored.
  - In DRAIN, the PPU keeps priority, so drain progress can stall indefinitely under continuous PPU reads.
- **Reset (asserted at any time):**
  - count=0 and pointers=0; buffered writes are discarded.
  - State goes to IDLE.
  - All outputs go to 0: `cpu_stall`, `ppu_rd_valid`, `drain_done`, `oam_we`, `oam_addr`, `oam_wdata`, `ppu_rd_data`.

## Timing
- Direct CPU write: `oam_we`/`oam_addr`/`oam_wdata` are combinational from the CPU inputs in the same cycle N.
- Buffered write: an entry enqueued in cycle N is eligible to write OAM no earlier than N+1. The drain rate is one entry per non-PPU cycle.
- PPU read requested in cycle N: `ppu_rd_valid`=1 and `ppu_rd_data` are valid in N+1. Back-to-back requests give back-to-back valids.
- Simultaneous enqueue and dequeue with count<DEPTH: count is unchanged and pointers both advance, wrapping modulo DEPTH.
- `drain_done` is high for exactly one cycle per forced drain.

## Test plan
- **Direct write.** Stimulus: count=0, no PPU; CPU writes addr 5 = 0xDEADBEEF. Required: `oam_we`=1 the same cycle, no stall; a PPU read of 5 two cycles later returns 0xDEADBEEF.
- **Collision and forwarding.** Stimulus: PPU reads continuously; CPU writes addr 3 = 0x11, then addr 3 = 0x22. Required: both are buffered with no `oam_we`; a PPU read of 3 returns 0x22; after the PPU stops, OAM is written with 0x11 then 0x22.
- **Full.** Stimulus: PPU busy; 5 consecutive CPU writes with DEPTH=4. Required: the first 4 are accepted and `cpu_stall`=1 on the 5th until the first dequeue cycle after the PPU releases; order is preserved across pointer wrap.
- **Forced drain.** Stimulus: 3 entries buffered; pulse `drain_req`; PPU idle. Required: the FSM enters DRAIN, any CPU write is stalled, 3 `oam_we` cycles occur, `drain_done` pulses once, then the FSM returns to IDLE.
- **Empty drain.** Stimulus: count=0; pulse `drain_req`. Required: `drain_done` pulses on the next cycle and no stall occurs.
- **Async reset mid-drain.** Stimulus: assert `rst_n`=0 between clock edges with 2 entries pending. Required: all outputs 0 immediately, count=0, and no pending write reaches OAM after release.
